// File: rtl/ferry_scheduler.sv
// Wolf/goat/cabbage ferry scheduler: plans safe boat trips toward a requested bank configuration.
// Optional embedded checks are compiled in when SAFETY_ASSERT_EN is defined.
module ferry_scheduler #(
  parameter int unsigned TRIP_CYCLES = 4,
  parameter logic [2:0]  CONFLICT    = 3'b011,
  parameter int unsigned MAX_TRIPS   = 15
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [2:0] tgt_i,
  output logic [2:0] sel_o,
  output logic       boat_bank_o,
  output logic [2:0] item_bank_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       stuck_o,
  output logic [7:0] trip_cnt_o
);

  localparam int unsigned ItemW = 3;
  localparam int unsigned CntW  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECIDE,
    S_CROSS,
    S_DONE,
    S_STUCK
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cyc_q, cyc_d;
  logic [CntW-1:0] trip_q, trip_d;
  logic [ItemW-1:0] sel_q, sel_d;
  logic [ItemW-1:0] items_q, items_d;
  logic [ItemW-1:0] tgt_q, tgt_d;
  logic [ItemW-1:0] last_q, last_d;
  logic             boat_q, boat_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             stuck_q, stuck_d;

  logic [ItemW-1:0] on_bank;
  logic [ItemW-1:0] safe_item;
  logic [ItemW-1:0] tier1, tier3, tier4;
  logic [ItemW-1:0] cand_sel;
  logic             cand_found;

  // A bank is safe when no enabled conflict pair has both members present.
  function automatic logic safe_f(input logic [ItemW-1:0] present);
    return !((CONFLICT[0] & present[0] & present[1]) |
             (CONFLICT[1] & present[1] & present[2]) |
             (CONFLICT[2] & present[0] & present[2]));
  endfunction

  function automatic logic [ItemW-1:0] lowest_f(input logic [ItemW-1:0] v);
    return v & (~v + ItemW'(1));
  endfunction

  // Cargo choice: tiered preference, lowest index within a tier.
  always_comb begin
    safe_item  = '0;
    cand_sel   = '0;
    cand_found = 1'b1;
    on_bank    = boat_q ? items_q : ~items_q;
    for (int i = 0; i < ItemW; i++) begin
      safe_item[i] = on_bank[i] & safe_f(on_bank & ~(ItemW'(1) << i));
    end
    tier1 = safe_item & (items_q ^ tgt_q) & ~last_q;
    tier3 = safe_item & ~last_q;
    tier4 = safe_item & last_q;
    if (|tier1) begin
      cand_sel = lowest_f(tier1);
    end else if (safe_f(on_bank)) begin
      cand_sel = '0;
    end else if (|tier3) begin
      cand_sel = lowest_f(tier3);
    end else if (|tier4) begin
      cand_sel = tier4;
    end else begin
      cand_found = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    trip_d  = trip_q;
    sel_d   = sel_q;
    items_d = items_q;
    tgt_d   = tgt_q;
    last_d  = last_q;
    boat_d  = boat_q;
    case (state_q)
      S_IDLE, S_DONE, S_STUCK: begin
        if (start_i) begin
          tgt_d   = tgt_i;
          trip_d  = '0;
          last_d  = '0;
          state_d = S_DECIDE;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_DECIDE: begin
        if (items_q == tgt_q) begin
          state_d = S_DONE;
        end else if (trip_q == CntW'(MAX_TRIPS)) begin
          state_d = S_STUCK;
        end else if (!cand_found) begin
          state_d = S_STUCK;
        end else begin
          sel_d   = cand_sel;
          cyc_d   = '0;
          state_d = S_CROSS;
        end
      end
      S_CROSS: begin
        if (cyc_q == CntW'(TRIP_CYCLES - 1)) begin
          boat_d  = ~boat_q;
          items_d = items_q ^ sel_q;
          last_d  = sel_q;
          trip_d  = (trip_q == '1) ? trip_q : trip_q + CntW'(1);
          sel_d   = '0;
          state_d = S_DECIDE;
        end else begin
          cyc_d = cyc_q + CntW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d  = (state_d == S_DECIDE) || (state_d == S_CROSS);
    done_d  = (state_d == S_DONE);
    stuck_d = (state_d == S_STUCK);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      trip_q  <= '0;
      sel_q   <= '0;
      items_q <= '0;
      tgt_q   <= '0;
      last_q  <= '0;
      boat_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      stuck_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      trip_q  <= trip_d;
      sel_q   <= sel_d;
      items_q <= items_d;
      tgt_q   <= tgt_d;
      last_q  <= last_d;
      boat_q  <= boat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      stuck_q <= stuck_d;
    end
  end

  assign sel_o       = sel_q;
  assign boat_bank_o = boat_q;
  assign item_bank_o = items_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign stuck_o     = stuck_q;
  assign trip_cnt_o  = trip_q;

`ifdef SAFETY_ASSERT_EN
  logic xfer_q;

  // Marks the cycle right after a crossing lands.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      xfer_q <= 1'b0;
    end else begin
      xfer_q <= (state_q == S_CROSS) && (cyc_q == CntW'(TRIP_CYCLES - 1));
    end
  end

  a_sel_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(sel_q));
  a_departed_safe: assert property (@(posedge clk_i) disable iff (!rst_ni)
    xfer_q |-> safe_f(boat_q ? ~items_q : items_q));
  a_done_match: assert property (@(posedge clk_i) disable iff (!rst_ni)
    done_q |-> (items_q == tgt_q));
  c_all_across: cover property (@(posedge clk_i) disable iff (!rst_ni)
    done_q && (items_q == 3'b111));
`endif

endmodule

// File: tb/tb_ferry_scheduler.sv
// Bench for ferry_scheduler: four parameter variants checked against a trip-level planning model.
module tb_ferry_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start [4];
  logic [2:0] tgt   [4];
  logic [2:0] sel   [4];
  logic       boat  [4];
  logic [2:0] items [4];
  logic       busy  [4];
  logic       done  [4];
  logic       stuck [4];
  logic [7:0] trip  [4];

  int n_tests = 0;
  int n_fail  = 0;

  logic       m_boat  [4];
  logic [2:0] m_items [4];
  logic [2:0] m_seq [$];
  bit         m_done;
  logic [2:0] obs_seq [$];

  ferry_scheduler u0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[0]), .tgt_i(tgt[0]), .sel_o(sel[0]),
    .boat_bank_o(boat[0]), .item_bank_o(items[0]), .busy_o(busy[0]), .done_o(done[0]),
    .stuck_o(stuck[0]), .trip_cnt_o(trip[0]));
  ferry_scheduler #(.CONFLICT(3'b111)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[1]), .tgt_i(tgt[1]), .sel_o(sel[1]),
    .boat_bank_o(boat[1]), .item_bank_o(items[1]), .busy_o(busy[1]), .done_o(done[1]),
    .stuck_o(stuck[1]), .trip_cnt_o(trip[1]));
  ferry_scheduler #(.MAX_TRIPS(3)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[2]), .tgt_i(tgt[2]), .sel_o(sel[2]),
    .boat_bank_o(boat[2]), .item_bank_o(items[2]), .busy_o(busy[2]), .done_o(done[2]),
    .stuck_o(stuck[2]), .trip_cnt_o(trip[2]));
  ferry_scheduler #(.TRIP_CYCLES(2), .CONFLICT(3'b101)) u3 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[3]), .tgt_i(tgt[3]), .sel_o(sel[3]),
    .boat_bank_o(boat[3]), .item_bank_o(items[3]), .busy_o(busy[3]), .done_o(done[3]),
    .stuck_o(stuck[3]), .trip_cnt_o(trip[3]));

  function automatic int tc_of(input int k);
    return (k == 3) ? 2 : 4;
  endfunction

  function automatic logic [2:0] conf_of(input int k);
    return (k == 1) ? 3'b111 : (k == 3) ? 3'b101 : 3'b011;
  endfunction

  function automatic int maxt_of(input int k);
    return (k == 2) ? 3 : 15;
  endfunction

  // Safe if the items left behind on the boat's bank contain no enabled pair.
  function automatic bit safe_dep(input logic [2:0] conf, input logic bt, input logic [2:0] it,
                                  input int cargo);
    bit p [3];
    for (int i = 0; i < 3; i++) p[i] = (it[i] == bt) && (i != cargo);
    return !((conf[0] && p[0] && p[1]) || (conf[1] && p[1] && p[2]) ||
             (conf[2] && p[0] && p[2]));
  endfunction

  // Plans the whole request trip by trip and advances the model banks of instance k.
  task automatic model_plan(input int k, input logic [2:0] t);
    logic       bt    = m_boat[k];
    logic [2:0] it    = m_items[k];
    logic [2:0] conf  = conf_of(k);
    int         last  = -1;
    int         trips = 0;
    int         pick;
    m_seq.delete();
    while (1) begin
      if (it == t) begin m_done = 1'b1; break; end
      if (trips == maxt_of(k)) begin m_done = 1'b0; break; end
      pick = -2;
      for (int i = 0; i < 3 && pick == -2; i++)
        if (i != last && it[i] == bt && it[i] != t[i] && safe_dep(conf, bt, it, i)) pick = i;
      if (pick == -2 && safe_dep(conf, bt, it, -1)) pick = -1;
      for (int i = 0; i < 3 && pick == -2; i++)
        if (i != last && it[i] == bt && safe_dep(conf, bt, it, i)) pick = i;
      if (pick == -2 && last >= 0 && it[last] == bt && safe_dep(conf, bt, it, last)) pick = last;
      if (pick == -2) begin m_done = 1'b0; break; end
      bt = ~bt;
      if (pick >= 0) it[pick] = ~it[pick];
      m_seq.push_back((pick >= 0) ? (3'b001 << pick) : 3'b000);
      last = pick;
      trips++;
    end
    m_boat[k]  = bt;
    m_items[k] = it;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      start[k] = 1'b0; tgt[k] = 3'b000; m_boat[k] = 1'b0; m_items[k] = 3'b000;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Issues one request to instance k and follows it trip by trip to done or stuck.
  task automatic run_inst(input int k, input logic [2:0] t, input bit glitch);
    int         tc = tc_of(k);
    int         n, idx, limit, cyc, fin_cyc;
    logic       pb;
    logic [2:0] pi, ps, exp_c, got_c;
    bit         fin;
    logic       mb;
    logic [2:0] mi;
    model_plan(k, t);
    n = m_seq.size();
    mb = m_boat[k];
    mi = m_items[k];
    obs_seq.delete();
    @(negedge clk);
    start[k] = 1'b1; tgt[k] = t;
    @(posedge clk);
    @(negedge clk);
    start[k] = 1'b0;
    n_tests++;
    if (trip[k] !== 8'd0 || busy[k] !== 1'b1 || stuck[k] !== 1'b0) begin
      n_fail++;
      $display("FAIL accept[%0d]: trip=%0d busy=%b stuck=%b, expected 0/1/0", k, trip[k], busy[k], stuck[k]);
    end
    pb = boat[k]; pi = items[k]; ps = sel[k];
    idx = 0; fin = 1'b0; fin_cyc = 0;
    limit = (maxt_of(k) + 1) * (1 + tc) + 4;
    for (cyc = 1; cyc <= limit && !fin; cyc++) begin
      if (glitch && cyc == tc + 2) begin start[k] = 1'b1; tgt[k] = 3'b000; end
      else if (glitch && cyc == tc + 3) begin start[k] = 1'b0; tgt[k] = t; end
      @(posedge clk);
      @(negedge clk);
      if (boat[k] !== pb) begin
        exp_c = (idx < n) ? m_seq[idx] : 3'b111;
        got_c = items[k] ^ pi;
        n_tests++;
        if (idx >= n || cyc != (idx + 1) * (1 + tc) || got_c !== exp_c || ps !== exp_c) begin
          n_fail++;
          $display("FAIL trip[%0d] #%0d: edge=%0d cargo=%b sel=%b, expected edge=%0d cargo=%b",
                   k, idx, cyc, got_c, ps, (idx + 1) * (1 + tc), exp_c);
        end
        obs_seq.push_back(got_c);
        idx++;
      end
      pb = boat[k]; pi = items[k]; ps = sel[k];
      if (done[k] === 1'b1 || stuck[k] === 1'b1) begin fin = 1'b1; fin_cyc = cyc; end
    end
    n_tests++;
    if (!fin) begin
      n_fail++;
      $display("FAIL timeout[%0d]: no done/stuck within %0d edges", k, limit);
    end else begin
      if (done[k] !== m_done || stuck[k] !== !m_done || fin_cyc != n * (1 + tc) + 1 || idx != n) begin
        n_fail++;
        $display("FAIL outcome[%0d]: done=%b stuck=%b edge=%0d trips=%0d, expected done=%b edge=%0d trips=%0d",
                 k, done[k], stuck[k], fin_cyc, idx, m_done, n * (1 + tc) + 1, n);
      end
    end
    n_tests++;
    if (trip[k] !== 8'(n) || items[k] !== mi || boat[k] !== mb) begin
      n_fail++;
      $display("FAIL final[%0d]: trip=%0d items=%b boat=%b, expected %0d %b %b",
               k, trip[k], items[k], boat[k], n, mi, mb);
    end
    @(negedge clk);
    n_tests++;
    if (done[k] !== 1'b0 || busy[k] !== 1'b0 || stuck[k] !== !m_done || sel[k] !== 3'b000 ||
        items[k] !== mi) begin
      n_fail++;
      $display("FAIL settle[%0d]: done=%b busy=%b stuck=%b sel=%b items=%b, expected 0 0 %b 000 %b",
               k, done[k], busy[k], stuck[k], sel[k], items[k], !m_done, mi);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if ({sel[k], boat[k], items[k], busy[k], done[k], stuck[k], trip[k]} !== 17'd0) begin
        n_fail++;
        $display("FAIL reset_vals[%0d]: got %h, expected 0", k,
                 {sel[k], boat[k], items[k], busy[k], done[k], stuck[k], trip[k]});
      end
    end
    start[0] = 1'b1; tgt[0] = 3'b111;
    @(posedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (sel[0] !== 3'b010 || busy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL first_cross: sel=%b busy=%b, expected 010 1", sel[0], busy[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({sel[0], boat[0], items[0], busy[0], done[0], stuck[0], trip[0]} !== 17'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %h, expected 0",
               {sel[0], boat[0], items[0], busy[0], done[0], stuck[0], trip[0]});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (busy[0] !== 1'b0 || sel[0] !== 3'b000 || boat[0] !== 1'b0 || trip[0] !== 8'd0) begin
      n_fail++;
      $display("FAIL post_reset_idle: busy=%b sel=%b boat=%b trip=%0d, expected 0 000 0 0",
               busy[0], sel[0], boat[0], trip[0]);
    end
  endtask

  task automatic test_null();
    run_inst(0, 3'b000, 1'b0);
  endtask

  task automatic test_classic();
    logic [2:0] exp_seq [7] = '{3'b010, 3'b000, 3'b001, 3'b010, 3'b100, 3'b000, 3'b010};
    run_inst(0, 3'b111, 1'b0);
    n_tests++;
    if (obs_seq.size() != 7 || trip[0] !== 8'd7 || items[0] !== 3'b111 || boat[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL classic_end: trips=%0d trip_cnt=%0d items=%b boat=%b, expected 7 7 111 1",
               obs_seq.size(), trip[0], items[0], boat[0]);
    end else begin
      for (int i = 0; i < 7; i++) begin
        n_tests++;
        if (obs_seq[i] !== exp_seq[i]) begin
          n_fail++;
          $display("FAIL classic_seq #%0d: cargo=%b, expected %b", i, obs_seq[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_busy_protect();
    apply_reset();
    run_inst(0, 3'b111, 1'b1);
    n_tests++;
    if (trip[0] !== 8'd7 || items[0] !== 3'b111) begin
      n_fail++;
      $display("FAIL busy_protect: trip=%0d items=%b, expected 7 111", trip[0], items[0]);
    end
  endtask

  task automatic test_unsolvable();
    run_inst(1, 3'b111, 1'b0);
    n_tests++;
    if (stuck[1] !== 1'b1 || trip[1] !== 8'd0 || items[1] !== 3'b000 || boat[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL unsolvable: stuck=%b trip=%0d items=%b boat=%b, expected 1 0 000 0",
               stuck[1], trip[1], items[1], boat[1]);
    end
  endtask

  task automatic test_livelock();
    run_inst(2, 3'b111, 1'b0);
    n_tests++;
    if (stuck[2] !== 1'b1 || trip[2] !== 8'd3) begin
      n_fail++;
      $display("FAIL livelock: stuck=%b trip=%0d, expected 1 3", stuck[2], trip[2]);
    end
    run_inst(2, m_items[2], 1'b0);
    n_tests++;
    if (stuck[2] !== 1'b0 || items[2] !== 3'b011) begin
      n_fail++;
      $display("FAIL livelock_recover: stuck=%b items=%b, expected 0 011", stuck[2], items[2]);
    end
  endtask

  task automatic test_random();
    int k;
    for (int i = 0; i < 24; i++) begin
      k = ($urandom_range(0, 1) == 0) ? 0 : 3;
      run_inst(k, 3'($urandom_range(0, 7)), 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin start[k] = 1'b0; tgt[k] = 3'b000; end
    test_reset();
    test_null();
    test_classic();
    test_busy_protect();
    test_unsolvable();
    test_livelock();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ferry_scheduler.md
Name: ferry_scheduler

Overview:
- Autonomous controller for the wolf/goat/cabbage river crossing. It sequences boat trips, picks the cargo for each trip under the safety constraints, and drives the one-hot cargo select.
- It owns the bank state of the man (boat) and the three items. On a start command it moves them to a requested target configuration.
- Sits above the crossing datapath and replaces free-running w/g/c stimulus with a legal, deterministic schedule.

Parameters:
- TRIP_CYCLES, 4, cycles the boat spends crossing; legal range 1..255.
- CONFLICT, 3'b011, conflict-pair mask: bit0 wolf-goat, bit1 goat-cabbage, bit2 wolf-cabbage.
- MAX_TRIPS, 15, livelock guard: trip count at which the block gives up and asserts stuck.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin scheduling; sampled only in IDLE, DONE or STUCK.
- tgt  input  3  target bank per item {c,g,w}; captured on accepted start.
- sel  output  3  one-hot cargo {c,g,w} during CROSS; 0 = empty trip or not crossing.
- boat_bank  output  1  current bank of man/boat.
- item_bank  output  3  current bank per item {c,g,w}.
- busy  output  1  high in DECIDE and CROSS.
- done  output  1  one-cycle pulse: item_bank equals captured tgt.
- stuck  output  1  sticky: no safe move exists, or MAX_TRIPS reached.
- trip_cnt  output  8  trips completed since the last accepted start.

Behaviour:
- Reset (async assert, sync release): state IDLE; boat_bank = 0, item_bank = 0, sel = 0, busy = 0, done = 0, stuck = 0, trip_cnt = 0, tgt_q = 0, last-cargo = none.
- States: IDLE, DECIDE, CROSS, DONE, STUCK.
- Accepted start: captures tgt into tgt_q, clears trip_cnt, stuck and last-cargo, then goes to DECIDE. Start is ignored in DECIDE and CROSS.
- DECIDE lasts 1 cycle and evaluates in this priority order:
  - item_bank == tgt_q: go to DONE.
  - trip_cnt == MAX_TRIPS: go to STUCK.
  - Otherwise pick cargo; if no candidate exists, go to STUCK. With a candidate, go to CROSS with sel registered.
- Safety predicate: a departure is safe if, on the departing bank after cargo removal, no pair enabled in CONFLICT has both members present.
- Cargo selection tiers, first non-empty tier wins. Within a tier, lowest index wins (w < g < c). The last-carried item is excluded from tiers 1 and 3.
  - Tier 1: items on the boat bank with item_bank != tgt_q and a safe departure.
  - Tier 2: empty trip, if safe.
  - Tier 3: any other item on the boat bank with a safe departure.
  - Tier 4: last-carried item, if on the boat bank and safe.
- CROSS lasts exactly TRIP_CYCLES cycles with sel held constant. On the final cycle edge:
  - boat_bank toggles.
  - The selected item's bank toggles.
  - last-cargo updates (none for an empty trip).
  - trip_cnt increments, saturating at 255.
  - Next state is DECIDE.
- Every trip, start to next DECIDE, costs 1 + TRIP_CYCLES cycles.
- DONE: done = 1 for exactly one cycle, then IDLE.
- STUCK: stuck held high and banks frozen until an accepted start (which re-plans from the current banks) or reset.
- A start with item_bank already equal to tgt gives DECIDE then DONE, with trip_cnt = 0.
- Reset mid-CROSS: trip is abandoned; all state returns to reset values.
- sel is 0 in every state except CROSS.
- The initial configuration is not validated. The block only guarantees the safety of the bank it departs from.

Optional Feature:
- Macro SAFETY_ASSERT_EN.
- Defined: embedded formal checks under clk are compiled in:
  - assert sel is zero or one-hot;
  - assert that after each reset-free CROSS completion the bank opposite boat_bank holds no CONFLICT pair;
  - assert done implies item_bank == tgt_q;
  - cover done with item_bank == 3'b111.
- Undefined: no assertion or cover logic; functional behaviour identical.

Test Plan:
- Reset: hold rst_n low mid-CROSS -> all outputs 0 asynchronously, state IDLE after release.
- Classic crossing: defaults, tgt = 3'b111, start -> sel sequence g, empty, w, g, c, empty, g. Then done pulses 36 edges after the start-sampling edge; trip_cnt = 7; item_bank = 111; boat_bank = 1.
- Null request: tgt = 3'b000 from reset, start -> done after 2 edges, trip_cnt = 0, sel never nonzero.
- Unsolvable: CONFLICT = 3'b111, tgt = 3'b111, start -> STUCK at first DECIDE, stuck = 1, trip_cnt = 0, banks unchanged.
- Livelock guard: MAX_TRIPS = 3, classic request -> stuck = 1 after 3 trips, trip_cnt = 3. Start with tgt = current item_bank -> stuck clears, done pulses.
- Busy protection: pulse start during CROSS of trip 2 with tgt = 3'b000 -> ignored; the original schedule completes with trip_cnt = 7.
